// File: rtl/seat_belt_chime.sv
// Seat-belt warning controller: registered body-sensor inputs, steady lamp and
// a pulsed chime with grace period, on/off cadence and timeout mute.
module seat_belt_chime #(
  parameter int NUM_SEATS   = 2,
  parameter int NUM_DOORS   = 2,
  parameter int TICK_DIV    = 4,
  parameter int GRACE_TICKS = 3,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 1,
  parameter int MAX_TICKS   = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Ignition,
  input  logic [NUM_DOORS-1:0] DoorClose,
  input  logic [NUM_SEATS-1:0] Occupied,
  input  logic [NUM_SEATS-1:0] SeatBelt,
  output logic                 Alarm,
  output logic                 Lamp,
  output logic                 DoorAjar,
  output logic [NUM_SEATS-1:0] UnbeltedMask
);

  // state   | meaning
  // IDLE    | no violation, lamp and chime off
  // GRACE   | violation seen, lamp on, waiting GRACE_TICKS before chiming
  // CHIME   | lamp on, chime pulses ON/OFF until MAX_TICKS elapse
  // TIMEOUT | lamp on, chime muted; a newly unbelted seat re-arms GRACE
  typedef enum logic [1:0] {IDLE, GRACE, CHIME, TIMEOUT} state_t;

  localparam int PW  = $clog2(TICK_DIV + 1);
  localparam int GW  = $clog2(GRACE_TICKS + 1);
  localparam int CW  = $clog2(MAX_TICKS + 1);
  localparam int PHW = $clog2(((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) + 1);

  localparam logic [PW-1:0]  PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0]  GRACE_LAST = GW'(GRACE_TICKS - 1);
  localparam logic [CW-1:0]  CHIME_LAST = CW'(MAX_TICKS - 1);
  localparam logic [PHW-1:0] ON_LAST    = PHW'(ON_TICKS - 1);
  localparam logic [PHW-1:0] OFF_LAST   = PHW'(OFF_TICKS - 1);

  logic                 ign_q;
  logic [NUM_DOORS-1:0] door_q;
  logic [NUM_SEATS-1:0] occ_q;
  logic [NUM_SEATS-1:0] belt_q;
  logic [NUM_SEATS-1:0] mask_q;

  logic [NUM_SEATS-1:0] occ_eff;
  logic [NUM_SEATS-1:0] mask_raw;
  logic                 v;
  logic                 rise;
  logic                 tick;

  state_t         state, state_nxt;
  logic [PW-1:0]  presc;
  logic [GW-1:0]  grace_cnt;
  logic [CW-1:0]  chime_cnt;
  logic [PHW-1:0] phase_cnt;
  logic [PHW-1:0] phase_last;
  logic           phase_off;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ign_q  <= 1'b0;
      door_q <= '0;
      occ_q  <= '0;
      belt_q <= '0;
      mask_q <= '0;
    end else begin
      ign_q  <= Ignition;
      door_q <= DoorClose;
      occ_q  <= Occupied;
      belt_q <= SeatBelt;
      mask_q <= mask_raw;
    end
  end

  // The driver seat is always considered occupied.
  always_comb begin
    occ_eff    = occ_q;
    occ_eff[0] = 1'b1;
  end

  assign mask_raw   = occ_eff & ~belt_q;
  assign v          = ign_q & (&door_q) & (|mask_raw);
  assign rise       = |(mask_raw & ~mask_q);
  assign tick       = (presc == PRE_LAST);
  assign phase_last = phase_off ? OFF_LAST : ON_LAST;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (v) state_nxt = GRACE;
      GRACE:   if (!v) state_nxt = IDLE;
               else if (tick && grace_cnt == GRACE_LAST) state_nxt = CHIME;
      CHIME:   if (!v) state_nxt = IDLE;
               else if (tick && chime_cnt == CHIME_LAST) state_nxt = TIMEOUT;
      TIMEOUT: if (!v) state_nxt = IDLE;
               else if (rise) state_nxt = GRACE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      presc     <= '0;
      grace_cnt <= '0;
      chime_cnt <= '0;
      phase_cnt <= '0;
      phase_off <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        presc     <= '0;
        grace_cnt <= '0;
        chime_cnt <= '0;
        phase_cnt <= '0;
        phase_off <= 1'b0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && state == GRACE && grace_cnt != GRACE_LAST)
          grace_cnt <= grace_cnt + 1'b1;
        if (tick && state == CHIME) begin
          if (chime_cnt != CHIME_LAST)
            chime_cnt <= chime_cnt + 1'b1;
          if (phase_cnt == phase_last) begin
            phase_off <= ~phase_off;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign Lamp         = (state != IDLE);
  assign Alarm        = (state == CHIME) && !phase_off;
  assign DoorAjar     = ign_q & ~(&door_q);
  // Mask is held at zero while Reset is applied, even though bit 0 is forced.
  assign UnbeltedMask = Reset ? '0 : mask_raw;

endmodule
